// File: rtl/wave_pkg.sv
// wave_pkg: selector codes and measurement states shared by the waveform generator and identifier
package wave_pkg;
  localparam logic [2:0] SEL_SINE   = 3'b110;
  localparam logic [2:0] SEL_SQUARE = 3'b101;
  localparam logic [2:0] SEL_TRI    = 3'b011;
  typedef enum logic [1:0] {S_IDLE, S_PEAK, S_CLASS, S_DECIDE} state_e;
endpackage

// File: rtl/wave_peak_track.sv
// wave_peak_track: running max/min of qualified samples with synchronous clear
module wave_peak_track #(
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] max_o,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] max_nxt_o,
  output logic [DW-1:0] min_nxt_o
);
  assign max_nxt_o = (valid_i && din_i > max_o) ? din_i : max_o;
  assign min_nxt_o = (valid_i && din_i < min_o) ? din_i : min_o;
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      max_o <= '0;
      min_o <= '1;
    end else begin
      max_o <= max_nxt_o;
      min_o <= min_nxt_o;
    end
  end
endmodule

// File: rtl/wave_ident.sv
// wave_ident: two-frame classifier of ADC waveforms into sine/square/triangle selector codes
module wave_ident
  import wave_pkg::*;
#(
  parameter int DW         = 14,
  parameter int FRAME_LOG2 = 10,
  parameter int MIN_PP     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ad_in,
  input  logic          ad_valid,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [2:0]    sel_out,
  output logic          sig_ok,
  output logic [DW-1:0] pp_out
);
  localparam int CW = FRAME_LOG2 + 1;
  localparam int N  = 1 << FRAME_LOG2;
  localparam logic [CW-1:0] SQ_TH    = CW'(3 * N / 4);
  localparam logic [CW-1:0] SI_TH    = CW'(3 * N / 8);
  localparam logic [DW-1:0] MIN_PP_W = DW'(MIN_PP);
  state_e                state_q;
  logic [FRAME_LOG2-1:0] cnt_q;
  logic [CW-1:0]         outer_q, outer_d;
  logic [DW-1:0]         band_q, max_w, min_w, max_nxt, min_nxt, pp_w, pk_pp, hi_th, lo_th;
  logic                  busy_q, done_q, sig_ok_q, hit, last;
  logic [2:0]            sel_q, sel_d;
  logic [DW-1:0]         pp_q;
  wave_peak_track #(.DW(DW)) u_peak (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == S_IDLE && start),
    .valid_i   (state_q == S_PEAK && ad_valid),
    .din_i     (ad_in),
    .max_o     (max_w),
    .min_o     (min_w),
    .max_nxt_o (max_nxt),
    .min_nxt_o (min_nxt)
  );
  // band is taken from the extrema including the final PEAK sample
  assign pk_pp   = max_nxt - min_nxt;
  assign pp_w    = max_w - min_w;
  assign hi_th   = max_w - band_q;
  assign lo_th   = min_w + band_q;
  assign hit     = ad_in >= hi_th || ad_in <= lo_th;
  assign outer_d = outer_q + CW'(hit);
  assign last    = &cnt_q;
  assign sel_d   = outer_d >= SQ_TH ? SEL_SQUARE : outer_d >= SI_TH ? SEL_SINE : SEL_TRI;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      outer_q  <= '0;
      band_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_ok_q <= 1'b0;
      sel_q    <= SEL_SINE;
      pp_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          state_q <= S_PEAK;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          outer_q <= '0;
        end
        S_PEAK: if (ad_valid) begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= S_CLASS;
            band_q  <= pk_pp >> 3;
          end
        end
        S_CLASS: if (ad_valid) begin
          cnt_q   <= cnt_q + 1'b1;
          outer_q <= outer_d;
          if (last) begin
            state_q  <= S_DECIDE;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            pp_q     <= pp_w;
            sig_ok_q <= pp_w >= MIN_PP_W;
            sel_q    <= pp_w >= MIN_PP_W ? sel_d : sel_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign sel_out = sel_q;
  assign sig_ok  = sig_ok_q;
  assign pp_out  = pp_q;
endmodule

// File: tb/tb_wave_ident.sv
// tb_wave_ident: directed scenarios for the waveform identifier at N=64, MIN_PP=64
module tb_wave_ident;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] ad_in = '0;
  logic        ad_valid = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, sig_ok;
  logic [2:0]  sel_out;
  logic [13:0] pp_out;
  int          n_checks = 0;
  int          n_fail = 0;

  wave_ident #(.DW(14), .FRAME_LOG2(6), .MIN_PP(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ad_in    (ad_in),
    .ad_valid (ad_valid),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .sel_out  (sel_out),
    .sig_ok   (sig_ok),
    .pp_out   (pp_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // k is the valid-sample index after start: 0..63 peak frame, 64..127 class frame
  function automatic logic [13:0] smp(input int mode, input int k);
    int j, v;
    j = k % 64;
    case (mode)
      0: v = (j < 32) ? 0 : 8000;
      1: v = (j < 32) ? j * 250 : (64 - j) * 250;
      2: v = $rtoi(8192.0 + 4000.0 * $sin(6.283185307179586 * j / 64.0));
      3: v = 4990 + (k * 5) % 21;
      4: v = (j < 32) ? 0 : 64;
      5: v = (j < 32) ? 0 : 63;
      6: v = (k < 64) ? ((j < 32) ? 0 : 8000) : ((j % 2 == 1) ? 7000 : 1000);
      7: v = (k < 64) ? ((j < 32) ? 0 : 8000) : ((j < 48) ? 0 : 4000);
      8: v = (k < 64) ? ((j < 32) ? 0 : 8000) : ((j < 47) ? 0 : 4000);
      9: v = (k < 64) ? ((j < 32) ? 0 : 8000) : ((j < 24) ? 0 : 4000);
      default: v = (k < 64) ? ((j < 32) ? 0 : 8000) : ((j < 23) ? 0 : 4000);
    endcase
    return 14'(v);
  endfunction

  task automatic run_meas(input int mode, input int gap, input bit junk_start, input bit extra_start,
                          output int early, output bit done_end, output bit busy_mid, output bit done_gone);
    @(negedge clk);
    start = 1'b1; ad_valid = junk_start; ad_in = 14'd16000;
    @(negedge clk);
    start = 1'b0; ad_valid = 1'b0;
    early = 0; busy_mid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      for (int g = 1; g < gap; g++) begin
        ad_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        if (done) early++;
        if (!busy) busy_mid = 1'b0;
      end
      ad_valid = 1'b1; ad_in = smp(mode, i); start = extra_start && i == 70;
      @(negedge clk);
      if (i < 127) begin
        if (done) early++;
        if (!busy) busy_mid = 1'b0;
      end
    end
    ad_valid = 1'b0;
    done_end = done && !busy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_gone = !done && !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (sel_out !== 3'b110) begin n_fail++; $display("FAIL reset_sel got %b want 110", sel_out); end
    n_checks++; if (sig_ok !== 1'b0) begin n_fail++; $display("FAIL reset_sig_ok got %b want 0", sig_ok); end
    n_checks++; if (pp_out !== 14'd0) begin n_fail++; $display("FAIL reset_pp got %0d want 0", pp_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_square();
    int early; bit de, bm, dg;
    run_meas(0, 1, 1'b1, 1'b0, early, de, bm, dg);
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL sq_early_done got %0d want 0", early); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL sq_done_at_129 got %b want 1", de); end
    n_checks++; if (bm !== 1'b1) begin n_fail++; $display("FAIL sq_busy_during got %b want 1", bm); end
    n_checks++; if (dg !== 1'b1) begin n_fail++; $display("FAIL sq_pulse_and_decide_start got %b want 1", dg); end
    n_checks++; if (sel_out !== 3'b101) begin n_fail++; $display("FAIL sq_sel got %b want 101", sel_out); end
    n_checks++; if (sig_ok !== 1'b1) begin n_fail++; $display("FAIL sq_sig_ok got %b want 1", sig_ok); end
    n_checks++; if (pp_out !== 14'd8000) begin n_fail++; $display("FAIL sq_pp got %0d want 8000", pp_out); end
  endtask

  task automatic test_triangle();
    int early; bit de, bm, dg;
    run_meas(1, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL tri_done got %b want 1", de); end
    n_checks++; if (sel_out !== 3'b011) begin n_fail++; $display("FAIL tri_sel got %b want 011", sel_out); end
    n_checks++; if (sig_ok !== 1'b1) begin n_fail++; $display("FAIL tri_sig_ok got %b want 1", sig_ok); end
    n_checks++; if (pp_out !== 14'd8000) begin n_fail++; $display("FAIL tri_pp got %0d want 8000", pp_out); end
  endtask

  task automatic test_noise();
    int early; bit de, bm, dg;
    run_meas(3, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL noise_done got %b want 1", de); end
    n_checks++; if (sig_ok !== 1'b0) begin n_fail++; $display("FAIL noise_sig_ok got %b want 0", sig_ok); end
    n_checks++; if (sel_out !== 3'b011) begin n_fail++; $display("FAIL noise_sel_held got %b want 011", sel_out); end
    n_checks++; if (pp_out !== 14'd20) begin n_fail++; $display("FAIL noise_pp got %0d want 20", pp_out); end
  endtask

  task automatic test_sine();
    int early; bit de, bm, dg;
    run_meas(2, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL sine_done got %b want 1", de); end
    n_checks++; if (sel_out !== 3'b110) begin n_fail++; $display("FAIL sine_sel got %b want 110", sel_out); end
    n_checks++; if (sig_ok !== 1'b1) begin n_fail++; $display("FAIL sine_sig_ok got %b want 1", sig_ok); end
  endtask

  task automatic test_pp_boundary();
    int early; bit de, bm, dg;
    run_meas(4, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (sig_ok !== 1'b1) begin n_fail++; $display("FAIL pp64_sig_ok got %b want 1", sig_ok); end
    n_checks++; if (sel_out !== 3'b101) begin n_fail++; $display("FAIL pp64_sel got %b want 101", sel_out); end
    n_checks++; if (pp_out !== 14'd64) begin n_fail++; $display("FAIL pp64_pp got %0d want 64", pp_out); end
    run_meas(1, 1, 1'b0, 1'b0, early, de, bm, dg);
    run_meas(5, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (sig_ok !== 1'b0) begin n_fail++; $display("FAIL pp63_sig_ok got %b want 0", sig_ok); end
    n_checks++; if (sel_out !== 3'b011) begin n_fail++; $display("FAIL pp63_sel_held got %b want 011", sel_out); end
    n_checks++; if (pp_out !== 14'd63) begin n_fail++; $display("FAIL pp63_pp got %0d want 63", pp_out); end
  endtask

  task automatic test_thresholds();
    int early; bit de, bm, dg;
    logic [2:0] want [5] = '{3'b101, 3'b101, 3'b110, 3'b110, 3'b011};
    for (int m = 0; m < 5; m++) begin
      run_meas(6 + m, 1, 1'b0, 1'b0, early, de, bm, dg);
      n_checks++;
      if (sel_out !== want[m]) begin
        n_fail++; $display("FAIL thresh_mode%0d_sel got %b want %b", 6 + m, sel_out, want[m]);
      end
    end
  endtask

  task automatic test_gap_extra_start();
    int early; bit de, bm, dg;
    run_meas(1, 1, 1'b0, 1'b0, early, de, bm, dg);
    run_meas(0, 3, 1'b0, 1'b1, early, de, bm, dg);
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL gap_early_done got %0d want 0", early); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL gap_done_after_128 got %b want 1", de); end
    n_checks++; if (bm !== 1'b1) begin n_fail++; $display("FAIL gap_busy_during got %b want 1", bm); end
    n_checks++; if (sel_out !== 3'b101) begin n_fail++; $display("FAIL gap_sel got %b want 101", sel_out); end
    n_checks++; if (pp_out !== 14'd8000) begin n_fail++; $display("FAIL gap_pp got %0d want 8000", pp_out); end
  endtask

  task automatic test_reset_mid_run();
    int early; bit de, bm, dg;
    @(negedge clk);
    start = 1'b1; ad_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ad_valid = 1'b1; ad_in = smp(0, i);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (sel_out !== 3'b110) begin n_fail++; $display("FAIL rstmid_sel got %b want 110", sel_out); end
    n_checks++; if (sig_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_sig_ok got %b want 0", sig_ok); end
    n_checks++; if (pp_out !== 14'd0) begin n_fail++; $display("FAIL rstmid_pp got %0d want 0", pp_out); end
    rst_n = 1'b1; ad_valid = 1'b0;
    @(negedge clk);
    run_meas(1, 1, 1'b0, 1'b0, early, de, bm, dg);
    n_checks++; if (early !== 0) begin n_fail++; $display("FAIL rstmid_rerun_early got %0d want 0", early); end
    n_checks++; if (de !== 1'b1) begin n_fail++; $display("FAIL rstmid_rerun_done got %b want 1", de); end
    n_checks++; if (sel_out !== 3'b011) begin n_fail++; $display("FAIL rstmid_rerun_sel got %b want 011", sel_out); end
    n_checks++; if (pp_out !== 14'd8000) begin n_fail++; $display("FAIL rstmid_rerun_pp got %0d want 8000", pp_out); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_triangle();
    test_noise();
    test_sine();
    test_pp_boundary();
    test_thresholds();
    test_gap_extra_start();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
